// File: rtl/hc_sb.sv
// ============================================================================
// Module   : hc_sb
// Purpose  : Scoreboarded pipeline hazard controller (busy/jump/RAW priority,
//            per-register pending-write counters). Optional hazard performance
//            counters are built when HC_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc_sb #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              je,
    input  logic              busy_E,
    input  logic              busy_M,
    input  logic              valid_D,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_D,
    input  logic              long_D,
    input  logic              wb_valid_W,
    input  logic [REG_AW-1:0] wb_rd_W,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_D,
    output logic              stall_E,
    output logic              flush_E,
    output logic              stall_M,
    output logic              flush_M,
    output logic              stall_W,
    output logic              flush_W,
    output logic              sb_err,
    output logic [PERF_W-1:0] perf_mem,
    output logic [PERF_W-1:0] perf_exe,
    output logic [PERF_W-1:0] perf_raw,
    output logic [PERF_W-1:0] perf_jmp
);

    localparam int               NREG    = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_err_q, sb_err_d;

    logic byp1, byp2, raw1, raw2, struct_haz, hazard;
    logic rule_mem, rule_exe, rule_jmp, rule_raw;
    logic issue, retire;

    // Writeback is written through, so a retiring write cancels one pending count.
    assign byp1 = wb_valid_W && (wb_rd_W == rs1_addr);
    assign byp2 = wb_valid_W && (wb_rd_W == rs2_addr);

    assign raw1 = rs1_used && (rs1_addr != '0) && (cnt_q[rs1_addr] > CNT_W'(byp1));
    assign raw2 = rs2_used && (rs2_addr != '0) && (cnt_q[rs2_addr] > CNT_W'(byp2));
    assign struct_haz = long_D && (rd_D != '0) && (cnt_q[rd_D] == CNT_MAX);
    assign hazard = valid_D && (raw1 || raw2 || struct_haz);

    assign rule_mem = busy_M;
    assign rule_exe = !busy_M && busy_E;
    assign rule_jmp = !busy_M && !busy_E && je;
    assign rule_raw = !busy_M && !busy_E && !je && hazard;

    assign stall_F = rule_mem || rule_exe || rule_raw;
    assign stall_D = rule_mem || rule_exe || rule_raw;
    assign flush_D = rule_jmp;
    assign stall_E = rule_mem || rule_exe;
    assign flush_E = rule_jmp || rule_raw;
    assign stall_M = rule_mem;
    assign flush_M = rule_exe;
    assign stall_W = 1'b0;
    assign flush_W = rule_mem;
    assign sb_err  = sb_err_q;

    assign issue  = valid_D && long_D && (rd_D != '0) &&
                    !(rule_mem || rule_exe || rule_jmp || rule_raw);
    assign retire = wb_valid_W && (wb_rd_W != '0);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        sb_err_d = sb_err_q;
        // Issue and retire of the same register cancel; the count is untouched.
        if (!(issue && retire && (rd_D == wb_rd_W))) begin
            if (issue) begin
                cnt_d[rd_D] = cnt_q[rd_D] + CNT_W'(1);
            end
            if (retire) begin
                if (cnt_q[wb_rd_W] == '0) begin
                    sb_err_d = 1'b1;
                end else begin
                    cnt_d[wb_rd_W] = cnt_q[wb_rd_W] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sb_err_q <= sb_err_d;
        end
    end

`ifdef HC_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;

    logic [PERF_W-1:0] perf_mem_q, perf_exe_q, perf_raw_q, perf_jmp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mem_q <= '0;
            perf_exe_q <= '0;
            perf_raw_q <= '0;
            perf_jmp_q <= '0;
        end else begin
            if (rule_mem && (perf_mem_q != PERF_MAX)) perf_mem_q <= perf_mem_q + PERF_W'(1);
            if (rule_exe && (perf_exe_q != PERF_MAX)) perf_exe_q <= perf_exe_q + PERF_W'(1);
            if (rule_raw && (perf_raw_q != PERF_MAX)) perf_raw_q <= perf_raw_q + PERF_W'(1);
            if (rule_jmp && (perf_jmp_q != PERF_MAX)) perf_jmp_q <= perf_jmp_q + PERF_W'(1);
        end
    end

    assign perf_mem = perf_mem_q;
    assign perf_exe = perf_exe_q;
    assign perf_raw = perf_raw_q;
    assign perf_jmp = perf_jmp_q;
`else
    assign perf_mem = '0;
    assign perf_exe = '0;
    assign perf_raw = '0;
    assign perf_jmp = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hc_sb.sv
// ============================================================================
// Module   : tb_hc_sb
// Purpose  : Self-checking bench for hc_sb: rule-level reference model plus
//            directed scenarios with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hc_sb;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 2;
    localparam int PERF_W = 32;
    localparam int MAXC   = (1 << CNT_W) - 1;

    // Packed order: stall_F stall_D flush_D stall_E flush_E stall_M flush_M stall_W flush_W
    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_MEM  = 9'b110101001;
    localparam logic [8:0] O_EXE  = 9'b110100100;
    localparam logic [8:0] O_JMP  = 9'b001010000;
    localparam logic [8:0] O_RAW  = 9'b110010000;

    logic clk = 1'b0;
    logic rst;
    logic je, busy_E, busy_M, valid_D, rs1_used, rs2_used, long_D, wb_valid_W;
    logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_D, wb_rd_W;
    logic stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_M, stall_W, flush_W;
    logic sb_err;
    logic [PERF_W-1:0] perf_mem, perf_exe, perf_raw, perf_jmp;

    int total = 0;
    int passed = 0;

    hc_sb #(.REG_AW(REG_AW), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst), .je(je), .busy_E(busy_E), .busy_M(busy_M),
        .valid_D(valid_D), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_D(rd_D), .long_D(long_D),
        .wb_valid_W(wb_valid_W), .wb_rd_W(wb_rd_W),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .stall_E(stall_E), .flush_E(flush_E), .stall_M(stall_M), .flush_M(flush_M),
        .stall_W(stall_W), .flush_W(flush_W), .sb_err(sb_err),
        .perf_mem(perf_mem), .perf_exe(perf_exe), .perf_raw(perf_raw), .perf_jmp(perf_jmp)
    );

    always #5 clk = ~clk;

    wire [8:0] outv = {stall_F, stall_D, flush_D, stall_E, flush_E,
                       stall_M, flush_M, stall_W, flush_W};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // ---------------- reference model ----------------
    int  m_cnt [1 << REG_AW];
    bit  m_err;
    longint m_pm, m_pe, m_pj, m_pr;

    function automatic bit m_pending(input int rs, input bit used);
        int eff;
        eff = m_cnt[rs] - ((wb_valid_W && (int'(wb_rd_W) == rs)) ? 1 : 0);
        return used && (rs != 0) && (eff > 0);
    endfunction

    function automatic int m_rule();
        bit haz;
        haz = valid_D && (m_pending(int'(rs1_addr), rs1_used) ||
                          m_pending(int'(rs2_addr), rs2_used) ||
                          (long_D && rd_D != 0 && m_cnt[rd_D] == MAXC));
        if (busy_M) return 1;
        if (busy_E) return 2;
        if (je)     return 3;
        if (haz)    return 4;
        return 0;
    endfunction

    function automatic logic [8:0] m_outs();
        case (m_rule())
            1:       return O_MEM;
            2:       return O_EXE;
            3:       return O_JMP;
            4:       return O_RAW;
            default: return O_NONE;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << REG_AW); i++) m_cnt[i] <= 0;
            m_err <= 1'b0;
            m_pm <= 0; m_pe <= 0; m_pj <= 0; m_pr <= 0;
        end else begin
            automatic int  r   = m_rule();
            automatic bit  iss = valid_D && long_D && rd_D != 0 && r == 0;
            automatic bit  ret = wb_valid_W && wb_rd_W != 0;
            if (!(iss && ret && rd_D == wb_rd_W)) begin
                if (iss) m_cnt[rd_D] <= m_cnt[rd_D] + 1;
                if (ret) begin
                    if (m_cnt[wb_rd_W] == 0) m_err <= 1'b1;
                    else m_cnt[wb_rd_W] <= m_cnt[wb_rd_W] - 1;
                end
            end
            if (r == 1) m_pm <= m_pm + 1;
            if (r == 2) m_pe <= m_pe + 1;
            if (r == 3) m_pj <= m_pj + 1;
            if (r == 4) m_pr <= m_pr + 1;
        end
    end

    function automatic logic [63:0] m_perf(input longint v);
`ifdef HC_PERF_EN
        return 64'(v);
`else
        return (v < 0) ? 64'd1 : 64'd0;
`endif
    endfunction

    always @(negedge clk) begin
        chk("model_outs", 64'(outv), 64'(m_outs()));
        chk("model_sb_err", 64'(sb_err), 64'(m_err));
        chk("model_perf_mem", 64'(perf_mem), m_perf(m_pm));
        chk("model_perf_exe", 64'(perf_exe), m_perf(m_pe));
        chk("model_perf_jmp", 64'(perf_jmp), m_perf(m_pj));
        chk("model_perf_raw", 64'(perf_raw), m_perf(m_pr));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        je = 0; busy_E = 0; busy_M = 0; valid_D = 0; rs1_used = 0; rs2_used = 0;
        long_D = 0; wb_valid_W = 0; rs1_addr = '0; rs2_addr = '0; rd_D = '0; wb_rd_W = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic long_op(input int rd);
        idle(); valid_D = 1; long_D = 1; rd_D = REG_AW'(rd);
    endtask

    task automatic wb(input int rd);
        wb_valid_W = 1; wb_rd_W = REG_AW'(rd);
    endtask

    task automatic use1(input int rs);
        idle(); valid_D = 1; rs1_used = 1; rs1_addr = REG_AW'(rs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        mid();
        chk("reset_outs", 64'(outv), 64'(O_NONE));
        chk("reset_sb_err", 64'(sb_err), 64'd0);
        next(); rst = 0;

        // Perf scenario: 4 mem, 2 exe, 1 jmp, 3 raw cycles.
        repeat (4) begin idle(); busy_M = 1; next(); end
        repeat (2) begin idle(); busy_E = 1; next(); end
        idle(); je = 1; next();
        long_op(9); next();
        repeat (3) begin use1(9); next(); end
        idle(); mid();
`ifdef HC_PERF_EN
        chk("perf_mem_lit", 64'(perf_mem), 64'd4);
        chk("perf_exe_lit", 64'(perf_exe), 64'd2);
        chk("perf_jmp_lit", 64'(perf_jmp), 64'd1);
        chk("perf_raw_lit", 64'(perf_raw), 64'd3);
`else
        chk("perf_off_lit", 64'(perf_mem | perf_exe | perf_jmp | perf_raw), 64'd0);
`endif
        next();

        // Load to x5, dependent stalls, released by matching writeback.
        long_op(5); next();
        use1(5); mid(); chk("raw_x5", 64'(outv), 64'(O_RAW)); next();
        use1(5); wb(5); mid(); chk("raw_x5_bypass", 64'(outv), 64'(O_NONE)); next();
        use1(5); mid(); chk("x5_clear", 64'(outv), 64'(O_NONE)); next();

        // Priority: busy_M beats je and RAW; then je beats RAW.
        long_op(6); next();
        use1(6); busy_M = 1; je = 1; mid(); chk("prio_mem", 64'(outv), 64'(O_MEM)); next();
        use1(6); je = 1; mid(); chk("prio_jmp", 64'(outv), 64'(O_JMP)); next();
        idle(); wb(6); next();

        // Structural limit on x7.
        repeat (3) begin long_op(7); next(); end
        long_op(7); mid(); chk("struct_full", 64'(outv), 64'(O_RAW)); next();
        long_op(7); wb(7); mid(); chk("struct_full_wb", 64'(outv), 64'(O_RAW)); next();
        long_op(7); mid(); chk("struct_issue", 64'(outv), 64'(O_NONE)); next();
        long_op(7); wb(7); mid(); chk("struct_full2", 64'(outv), 64'(O_RAW)); next();
        long_op(7); wb(7); mid(); chk("struct_cancel", 64'(outv), 64'(O_NONE)); next();
        long_op(7); mid(); chk("struct_after_cancel", 64'(outv), 64'(O_NONE)); next();
        long_op(7); mid(); chk("struct_full3", 64'(outv), 64'(O_RAW)); next();
        repeat (3) begin idle(); wb(7); next(); end

        // x0 is never pending; retiring an idle register sets sticky error.
        long_op(0); rs1_used = 1; rs2_used = 1; mid();
        chk("x0_long", 64'(outv), 64'(O_NONE)); next();
        use1(0); rs2_used = 1; mid(); chk("x0_src", 64'(outv), 64'(O_NONE)); next();
        idle(); wb(3); mid(); chk("err_before", 64'(sb_err), 64'd0); next();
        idle(); mid(); chk("err_set", 64'(sb_err), 64'd1); next();
        repeat (2) next();
        mid(); chk("err_sticky", 64'(sb_err), 64'd1);
        next();

        // Async reset mid-stall with cnt[9] = 2.
        long_op(9); next();
        use1(9); mid(); chk("x9_stall", 64'(outv), 64'(O_RAW));
        #2 rst = 1;
        #1 chk("async_rst_outs", 64'(outv), 64'(O_NONE));
        chk("async_rst_err", 64'(sb_err), 64'd0);
        next(); rst = 0;
        use1(9); mid(); chk("x9_after_rst", 64'(outv), 64'(O_NONE)); next();
        idle(); next();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
